dvp_axis_pack: RTL and testbench

DVP_AXIS_PACK -- requirements
Module: dvp_axis_pack

---
 rtl/dvp_axis_pack.sv | 185 ++++++++++++++++++
 tb/tb_dvp_axis_pack.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_axis_pack.sv
// dvp_axis_pack
// Packs a DVP camera byte stream into AXI4-Stream pixels.
// Each pixel is BEATS_P consecutive hsync-qualified beats, packed big-endian.
// A one-entry pending stage holds the newest pixel until we know whether it
// ends the line (tlast). Closed pixels go into a first-word-fall-through FIFO.
//
// Ports
//   pclk_i, rstn_i     : clock, asynchronous active-low reset
//   vsync_i            : frame sync, rising edge starts a frame
//   hsync_i, data_i    : line valid and DVP beat
//   tdata_o .. tvalid_o: AXI4-Stream master (tkeep/tstrb tied high)
//   tready_i           : sink ready
//   overflow_o         : sticky, a pixel was dropped on a full FIFO
//   frag_o             : sticky, a line ended with a partial pixel
// Both sticky flags are cleared by the next vsync rise.
module dvp_axis_pack #(
   parameter int WIDTH_P = 8,
   parameter int BEATS_P = 2,
   parameter int DEPTH_P = 16
) (
   input  logic                           pclk_i,
   input  logic                           rstn_i,
   input  logic                           vsync_i,
   input  logic                           hsync_i,
   input  logic [WIDTH_P-1:0]             data_i,
   output logic [WIDTH_P*BEATS_P-1:0]     tdata_o,
   output logic [WIDTH_P*BEATS_P/8-1:0]   tkeep_o,
   output logic [WIDTH_P*BEATS_P/8-1:0]   tstrb_o,
   output logic                           tuser_o,
   output logic                           tlast_o,
   output logic                           tvalid_o,
   input  logic                           tready_i,
   output logic                           overflow_o,
   output logic                           frag_o
);

   localparam int PW = WIDTH_P * BEATS_P;
   localparam int AW = $clog2(DEPTH_P);
   localparam int CW = (BEATS_P > 1) ? $clog2(BEATS_P) : 1;
   localparam int EW = PW + 2;

   // input stage S1 and its one-cycle history for edge detection
   logic               vs1_q, hs1_q, vs2_q, hs2_q;
   logic [WIDTH_P-1:0] d1_q;

   logic [CW-1:0]      cnt_q, cnt_d;
   logic [PW-1:0]      acc_q, acc_d;
   logic               pend_v_q, pend_v_d;
   logic [PW-1:0]      pend_data_q, pend_data_d;
   logic               pend_user_q, pend_user_d;
   logic               sof_q, sof_d;
   logic               ovf_q, ovf_d;
   logic               frag_q, frag_d;

   logic [AW:0]        wr_ptr_q, wr_ptr_d;
   logic [AW:0]        rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]      mem_q [DEPTH_P];

   logic               vs_rise, hs_fall, beat, pix_done;
   logic [PW-1:0]      pix;
   logic               wr_en, frag_set, ovf_set;
   logic [EW-1:0]      wr_entry;
   logic               empty, full, push, pop;
   logic [EW-1:0]      head;

   assign vs_rise  = vs1_q & ~vs2_q;
   assign hs_fall  = ~hs1_q & hs2_q;
   // a vsync rise restarts the beat count, so a beat landing on it is ignored
   assign beat     = hs1_q & ~vs_rise;
   assign pix_done = beat && (cnt_q == CW'(BEATS_P - 1));
   // shifting left each beat leaves the first beat in the MSBs
   assign pix      = (acc_q << WIDTH_P) | PW'(d1_q);

   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      pend_v_d    = pend_v_q;
      pend_data_d = pend_data_q;
      pend_user_d = pend_user_q;
      sof_d       = sof_q;
      wr_en       = 1'b0;
      wr_entry    = '0;
      frag_set    = 1'b0;

      if (beat) begin
         acc_d = pix;
         if (pix_done) begin
            cnt_d = '0;
            if (pend_v_q) begin
               wr_en    = 1'b1;
               wr_entry = {pend_user_q, 1'b0, pend_data_q};
            end
            pend_v_d    = 1'b1;
            pend_data_d = pix;
            pend_user_d = sof_q;
            sof_d       = 1'b0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      // beat and hs_fall are exclusive (hs1 high vs low)
      if (hs_fall) begin
         if (cnt_q != '0) frag_set = 1'b1;
         cnt_d = '0;
         if (pend_v_q) begin
            wr_en    = 1'b1;
            wr_entry = {pend_user_q, 1'b1, pend_data_q};
         end
         pend_v_d = 1'b0;
      end

      if (vs_rise) begin
         sof_d = 1'b1;
         cnt_d = '0;
      end
   end

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = ~empty & tready_i;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push  = wr_en & (~full | pop);
   assign ovf_set = wr_en & full & ~pop;

   assign wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
   assign rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

   // set wins over the vsync clear
   assign ovf_d  = ovf_set  | (ovf_q  & ~vs_rise);
   assign frag_d = frag_set | (frag_q & ~vs_rise);

   always_ff @(posedge pclk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         vs1_q       <= 1'b0;
         hs1_q       <= 1'b0;
         d1_q        <= '0;
         vs2_q       <= 1'b0;
         hs2_q       <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         pend_v_q    <= 1'b0;
         pend_data_q <= '0;
         pend_user_q <= 1'b0;
         sof_q       <= 1'b0;
         ovf_q       <= 1'b0;
         frag_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         vs1_q       <= vsync_i;
         hs1_q       <= hsync_i;
         d1_q        <= data_i;
         vs2_q       <= vs1_q;
         hs2_q       <= hs1_q;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         pend_v_q    <= pend_v_d;
         pend_data_q <= pend_data_d;
         pend_user_q <= pend_user_d;
         sof_q       <= sof_d;
         ovf_q       <= ovf_d;
         frag_q      <= frag_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // storage needs no reset: it is only visible through a non-empty pointer pair
   always_ff @(posedge pclk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
   end

   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign tvalid_o   = ~empty;
   assign tdata_o    = empty ? '0 : head[PW-1:0];
   assign tlast_o    = ~empty & head[PW];
   assign tuser_o    = ~empty & head[PW+1];
   assign tkeep_o    = '1;
   assign tstrb_o    = '1;
   assign overflow_o = ovf_q;
   assign frag_o     = frag_q;

endmodule

// File: tb/tb_dvp_axis_pack.sv
module tb_dvp_axis_pack;

   logic        pclk = 1'b0;
   logic        rstn = 1'b0;
   logic        vsync = 1'b0;
   logic        hsync = 1'b0;
   logic [7:0]  data = '0;
   logic        tready_a = 1'b0;
   logic        tready_b = 1'b0;

   logic [15:0] tdata_a, tdata_b;
   logic [1:0]  tkeep_a, tstrb_a, tkeep_b, tstrb_b;
   logic        tuser_a, tlast_a, tvalid_a, ovf_a, frag_a;
   logic        tuser_b, tlast_b, tvalid_b, ovf_b, frag_b;

   int total = 0;
   int bad   = 0;
   bit rand_bp = 1'b0;

   logic [17:0] qa[$];
   logic [17:0] qb[$];

   always #5 pclk = ~pclk;

   // a: default depth 16, b: depth 4
   dvp_axis_pack u_dut_a (
      .pclk_i(pclk), .rstn_i(rstn), .vsync_i(vsync), .hsync_i(hsync), .data_i(data),
      .tdata_o(tdata_a), .tkeep_o(tkeep_a), .tstrb_o(tstrb_a), .tuser_o(tuser_a),
      .tlast_o(tlast_a), .tvalid_o(tvalid_a), .tready_i(tready_a),
      .overflow_o(ovf_a), .frag_o(frag_a));

   dvp_axis_pack #(.DEPTH_P(4)) u_dut_b (
      .pclk_i(pclk), .rstn_i(rstn), .vsync_i(vsync), .hsync_i(hsync), .data_i(data),
      .tdata_o(tdata_b), .tkeep_o(tkeep_b), .tstrb_o(tstrb_b), .tuser_o(tuser_b),
      .tlast_o(tlast_b), .tvalid_o(tvalid_b), .tready_i(tready_b),
      .overflow_o(ovf_b), .frag_o(frag_b));

   // record every accepted beat as {tuser, tlast, tdata}
   always @(posedge pclk) begin
      if (tvalid_a && tready_a) qa.push_back({tuser_a, tlast_a, tdata_a});
      if (tvalid_b && tready_b) qb.push_back({tuser_b, tlast_b, tdata_b});
   end

   task automatic tick();
      @(negedge pclk);
      if (rand_bp) tready_a = 1'($urandom_range(0, 1));
   endtask

   task automatic put(input logic [7:0] b);
      tick();
      hsync = 1'b1;
      data  = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         hsync = 1'b0;
         data  = '0;
      end
   endtask

   task automatic vpulse();
      tick();
      hsync = 1'b0;
      vsync = 1'b1;
      tick();
      tick();
      vsync = 1'b0;
      idle(3);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge pclk);
      total++; if (tvalid_a !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b want=0", tvalid_a); end
      total++; if (tdata_a !== 16'h0) begin bad++; $display("FAIL rst_tdata got=%h want=0000", tdata_a); end
      total++; if ({tuser_a, tlast_a} !== 2'b00) begin bad++; $display("FAIL rst_user_last got=%b want=00", {tuser_a, tlast_a}); end
      total++; if ({ovf_a, frag_a, ovf_b, frag_b} !== 4'b0) begin bad++; $display("FAIL rst_sticky got=%b want=0000", {ovf_a, frag_a, ovf_b, frag_b}); end
      total++; if ({tkeep_a, tstrb_a} !== 4'b1111) begin bad++; $display("FAIL keep_strb got=%b want=1111", {tkeep_a, tstrb_a}); end
      rstn = 1'b1;
      idle(2);
   endtask

   task automatic test_basic();
      tready_a = 1'b1;
      tready_b = 1'b1;
      qa.delete();
      vpulse();
      put(8'h12); put(8'h34); put(8'h56); put(8'h78);
      idle(10);
      total++; if (qa.size() !== 2) begin bad++; $display("FAIL basic_count got=%0d want=2", qa.size()); end
      else begin
         total++; if (qa[0] !== {2'b10, 16'h1234}) begin bad++; $display("FAIL basic_px0 got=%h want=%h", qa[0], {2'b10, 16'h1234}); end
         total++; if (qa[1] !== {2'b01, 16'h5678}) begin bad++; $display("FAIL basic_px1 got=%h want=%h", qa[1], {2'b01, 16'h5678}); end
      end
      total++; if (frag_a !== 1'b0) begin bad++; $display("FAIL basic_frag got=%b want=0", frag_a); end
   endtask

   task automatic test_frag();
      qa.delete();
      put(8'h01); put(8'h02); put(8'h03); put(8'h04); put(8'h05);
      idle(10);
      total++; if (qa.size() !== 2) begin bad++; $display("FAIL frag_count got=%0d want=2", qa.size()); end
      else begin
         total++; if (qa[0] !== {2'b00, 16'h0102}) begin bad++; $display("FAIL frag_px0 got=%h want=%h", qa[0], {2'b00, 16'h0102}); end
         total++; if (qa[1] !== {2'b01, 16'h0304}) begin bad++; $display("FAIL frag_px1 got=%h want=%h", qa[1], {2'b01, 16'h0304}); end
      end
      total++; if (frag_a !== 1'b1) begin bad++; $display("FAIL frag_set got=%b want=1", frag_a); end
      vpulse();
      total++; if (frag_a !== 1'b0) begin bad++; $display("FAIL frag_clear got=%b want=0", frag_a); end
   endtask

   task automatic test_overflow();
      logic [15:0] exp_px [4] = '{16'hA0A1, 16'hA2A3, 16'hA4A5, 16'hA6A7};
      tready_a = 1'b1;
      tready_b = 1'b0;
      qa.delete();
      qb.delete();
      for (int j = 0; j < 12; j++) put(8'hA0 + 8'(j));
      idle(5);
      total++; if (ovf_b !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf_b); end
      total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_deep got=%b want=0", ovf_a); end
      total++; if ({tvalid_b, tuser_b, tdata_b} !== {2'b11, 16'hA0A1}) begin bad++; $display("FAIL ovf_head got=%h want=%h", {tvalid_b, tuser_b, tdata_b}, {2'b11, 16'hA0A1}); end
      idle(3);
      total++; if ({tvalid_b, tuser_b, tlast_b, tdata_b} !== {3'b110, 16'hA0A1}) begin bad++; $display("FAIL ovf_stable got=%h want=%h", {tvalid_b, tuser_b, tlast_b, tdata_b}, {3'b110, 16'hA0A1}); end
      total++; if (qa.size() !== 6) begin bad++; $display("FAIL ovf_deep_count got=%0d want=6", qa.size()); end
      tready_b = 1'b1;
      idle(8);
      total++; if (qb.size() !== 4) begin bad++; $display("FAIL ovf_count got=%0d want=4", qb.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (qb[i] !== {(i == 0), 1'b0, exp_px[i]}) begin
               bad++; $display("FAIL ovf_px%0d got=%h want=%h", i, qb[i], {(i == 0), 1'b0, exp_px[i]});
            end
         end
      end
   endtask

   task automatic test_full_pushpop();
      vpulse();
      total++; if (ovf_b !== 1'b0) begin bad++; $display("FAIL full_vs_clear got=%b want=0", ovf_b); end
      tready_b = 1'b0;
      qb.delete();
      for (int j = 0; j < 12; j++) put(8'hB0 + 8'(j));
      // FIFO now holds 4; the next edge both pops and pushes
      tick();
      hsync = 1'b0;
      data  = '0;
      tready_b = 1'b1;
      total++; if (tvalid_b !== 1'b1) begin bad++; $display("FAIL full_valid got=%b want=1", tvalid_b); end
      tick();
      total++; if (ovf_b !== 1'b0) begin bad++; $display("FAIL full_pushpop_ovf got=%b want=0", ovf_b); end
      idle(10);
      total++; if (ovf_b !== 1'b0) begin bad++; $display("FAIL full_end_ovf got=%b want=0", ovf_b); end
      total++; if (qb.size() !== 6) begin bad++; $display("FAIL full_count got=%0d want=6", qb.size()); end
      else begin
         for (int i = 0; i < 6; i++) begin
            logic [15:0] v;
            v = {8'hB0 + 8'(2 * i), 8'hB1 + 8'(2 * i)};
            total++;
            if (qb[i] !== {(i == 0), (i == 5), v}) begin
               bad++; $display("FAIL full_px%0d got=%h want=%h", i, qb[i], {(i == 0), (i == 5), v});
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      tready_a = 1'b0;
      qa.delete();
      for (int j = 0; j < 9; j++) put(8'hC0 + 8'(j));
      tick();
      total++; if (tvalid_a !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%b want=1", tvalid_a); end
      rstn = 1'b0;
      #1;
      total++; if ({tvalid_a, tdata_a} !== 17'h0) begin bad++; $display("FAIL rmid_async got=%h want=0", {tvalid_a, tdata_a}); end
      hsync = 1'b0;
      data  = '0;
      idle(3);
      rstn = 1'b1;
      idle(2);
      tready_a = 1'b1;
      qa.delete();
      put(8'hD1); put(8'hD2); put(8'hD3); put(8'hD4);
      idle(8);
      total++; if (qa.size() !== 2) begin bad++; $display("FAIL rmid_count got=%0d want=2", qa.size()); end
      else begin
         total++; if (qa[0] !== {2'b00, 16'hD1D2}) begin bad++; $display("FAIL rmid_px0 got=%h want=%h", qa[0], {2'b00, 16'hD1D2}); end
         total++; if (qa[1] !== {2'b01, 16'hD3D4}) begin bad++; $display("FAIL rmid_px1 got=%h want=%h", qa[1], {2'b01, 16'hD3D4}); end
      end
   endtask

   task automatic test_backpressure();
      logic [17:0] ea[$];
      logic [15:0] v;
      int errs;
      tready_b = 1'b1;
      qa.delete();
      rand_bp = 1'b1;
      for (int f = 0; f < 3; f++) begin
         vpulse();
         for (int l = 0; l < 8; l++) begin
            for (int p = 0; p < 16; p++) begin
               v = 16'(f * 128 + l * 16 + p);
               put(v[15:8]);
               put(v[7:0]);
               ea.push_back({(l == 0 && p == 0), (p == 15), v});
            end
            idle(20);
         end
      end
      rand_bp = 1'b0;
      tready_a = 1'b1;
      idle(40);
      total++; if (qa.size() !== ea.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", qa.size(), ea.size()); end
      errs = 0;
      for (int i = 0; i < ea.size() && i < qa.size(); i++) begin
         total++;
         if (qa[i] !== ea[i]) begin
            bad++;
            if (errs < 10) $display("FAIL bp_px%0d got=%h want=%h", i, qa[i], ea[i]);
            errs++;
         end
      end
      total++; if ({ovf_a, frag_a} !== 2'b00) begin bad++; $display("FAIL bp_sticky got=%b want=00", {ovf_a, frag_a}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_frag();
      test_overflow();
      test_full_pushpop();
      test_reset_mid();
      test_backpressure();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
